img_mem_arbiter: RTL

IMG_MEM_ARBITER -- requirements
Module: img_mem_arbiter

---
 rtl/img_mem_arbiter_if.sv | 14 +
 rtl/img_mem_arbiter.sv | 60 ++++++
 2 files changed

// File: rtl/img_mem_arbiter_if.sv
// img_mem_arbiter_if: reader/writer handshakes and the single-port RAM bus
interface img_mem_arbiter_if #(parameter int ADDR_W = 17, parameter int DATA_W = 8);
  logic rd_req, rd_gnt, rd_valid, wr_req, wr_gnt, mem_en, mem_we;
  logic [ADDR_W-1:0] rd_addr, wr_addr, mem_addr;
  logic [DATA_W-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: read-priority RAM arbiter with a bounded writer wait and out-of-range guard
module img_mem_arbiter #(
  parameter int IMG_WIDTH  = 356,
  parameter int IMG_HEIGHT = 356,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  img_mem_arbiter_if.slave bus,
  output logic        err_oob,
  output logic [15:0] forced_cnt
);
  localparam logic [31:0] PIX = 32'(IMG_WIDTH * IMG_HEIGHT);
  localparam int WW = $clog2(MAX_WAIT + 2);
  logic [WW-1:0] wait_cnt;
  logic forced, rd_oob, wr_oob, rd_v1, rd_v2, rd_z1, rd_z2;
  always_comb begin
    forced       = bus.wr_req && wait_cnt == WW'(MAX_WAIT);
    bus.rd_gnt   = rst && bus.rd_req && !forced;
    bus.wr_gnt   = rst && bus.wr_req && (forced || !bus.rd_req);
    rd_oob       = 32'(bus.rd_addr) >= PIX;
    wr_oob       = 32'(bus.wr_addr) >= PIX;
    bus.rd_valid = rd_v2;
    bus.rd_data  = rd_v2 && !rd_z2 ? bus.mem_rdata : '0;
  end
  // a waiting writer is always granted once it reaches MAX_WAIT, so the counter cannot overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt      <= '0;
      forced_cnt    <= '0;
      err_oob       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rd_v1         <= 1'b0;
      rd_v2         <= 1'b0;
      rd_z1         <= 1'b0;
      rd_z2         <= 1'b0;
    end else begin
      wait_cnt   <= bus.wr_req && !bus.wr_gnt ? wait_cnt + WW'(1) : '0;
      forced_cnt <= forced && !(&forced_cnt) ? forced_cnt + 16'd1 : forced_cnt;
      err_oob    <= err_oob | (bus.rd_gnt && rd_oob) | (bus.wr_gnt && wr_oob);
      bus.mem_en <= (bus.rd_gnt && !rd_oob) || (bus.wr_gnt && !wr_oob);
      bus.mem_we <= bus.wr_gnt && !wr_oob;
      if (bus.rd_gnt && !rd_oob)
        bus.mem_addr <= bus.rd_addr;
      if (bus.wr_gnt && !wr_oob) begin
        bus.mem_addr  <= bus.wr_addr;
        bus.mem_wdata <= bus.wr_data;
      end
      rd_v1 <= bus.rd_gnt;
      rd_z1 <= rd_oob;
      rd_v2 <= rd_v1;
      rd_z2 <= rd_z1;
    end
  end
endmodule
